// File: rtl/debug_scan_if.sv
// rtl/debug_scan_if.sv - scan output stream: captured word, its address and last marker
interface debug_scan_if;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [31:0] out_addr;
    logic        out_last;

    modport master (
        output out_valid,
        input  out_ready,
        output out_data,
        output out_addr,
        output out_last
    );

    modport slave (
        input  out_valid,
        output out_ready,
        input  out_data,
        input  out_addr,
        input  out_last
    );
endinterface

// File: rtl/debug_scan.sv
// rtl/debug_scan.sv - debug-bus scan engine; checksum built only when DEBUG_SCAN_SUM_EN is defined
module debug_scan #(
    parameter int unsigned WAIT_CYC = 1
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               start,
    input  logic               abort,
    input  logic [31:0]        base_addr,
    input  logic [15:0]        length,
    output logic               busy,
    output logic               done,
    output logic [31:0]        chk_addr,
    input  logic [31:0]        chk_data,
    debug_scan_if.master       stream,
    output logic [31:0]        sum
);

    typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

    localparam logic [3:0] SETTLE_RELOAD = 4'(WAIT_CYC);

    state_t      state_q, state_d;
    logic [15:0] remaining_q;
    logic [3:0]  settle_q;
    logic        accept, zero_start, capture, handshake;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        accept     = 1'b0;
        zero_start = 1'b0;
        capture    = 1'b0;
        handshake  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (length != 16'd0) begin
                        accept  = 1'b1;
                        state_d = SETTLE;
                    end else begin
                        zero_start = 1'b1;
                    end
                end
            end
            SETTLE: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (settle_q == 4'd0) begin
                    capture = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                // abort wins over a handshake landing on the same edge
                if (abort) begin
                    state_d = IDLE;
                end else if (stream.out_valid && stream.out_ready) begin
                    handshake = 1'b1;
                    state_d   = stream.out_last ? IDLE : SETTLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            busy             <= 1'b0;
            done             <= 1'b0;
            chk_addr         <= 32'h0;
            remaining_q      <= 16'h0;
            settle_q         <= 4'h0;
            stream.out_valid <= 1'b0;
            stream.out_data  <= 32'h0;
            stream.out_addr  <= 32'h0;
            stream.out_last  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                chk_addr    <= base_addr;
                remaining_q <= length;
                settle_q    <= SETTLE_RELOAD;
                busy        <= 1'b1;
            end
            if (zero_start) done <= 1'b1;
            if (state_q != IDLE && abort) begin
                busy             <= 1'b0;
                stream.out_valid <= 1'b0;
                stream.out_last  <= 1'b0;
            end else begin
                if (state_q == SETTLE && settle_q != 4'd0) settle_q <= settle_q - 4'd1;
                if (capture) begin
                    stream.out_data  <= chk_data;
                    stream.out_addr  <= chk_addr;
                    stream.out_valid <= 1'b1;
                    stream.out_last  <= (remaining_q == 16'd1);
                end
                if (handshake) begin
                    stream.out_valid <= 1'b0;
                    if (stream.out_last) begin
                        stream.out_last <= 1'b0;
                        busy            <= 1'b0;
                        done            <= 1'b1;
                    end else begin
                        remaining_q    <= remaining_q - 16'd1;
                        // region select in [31:16] is fixed for the whole scan
                        chk_addr[15:0] <= chk_addr[15:0] + 16'd1;
                        settle_q       <= SETTLE_RELOAD;
                    end
                end
            end
        end
    end

`ifdef DEBUG_SCAN_SUM_EN
    logic [31:0] sum_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                    sum_q <= 32'h0;
        else if (accept || zero_start) sum_q <= 32'h0;
        else if (capture && !abort)   sum_q <= sum_q + chk_data;
    end

    assign sum = sum_q;
`else
    assign sum = 32'h0;
`endif

endmodule
